ahb_slave_mux: RTL and testbench

AHB-Lite address decoder and response multiplexer between the single system AHB master and up to HSLV_NUM AHB slaves, one of which is the AHB-to-APB bridge in region 4 (0x4000_0000–0x4FFF_FFFF). It drives the address-phase slave selects. It tracks which slave owns the current data phase and routes that slave's HREADYOUT/HRESP/HRDATA back to the master. An internal default slave returns the two-cycle AHB ERROR response for accesses to unmapped regions.

---
 rtl/ahb_slave_mux_if.sv | 27 ++
 rtl/ahb_slave_mux.sv | 131 +++++++++++++
 tb/tb_ahb_slave_mux.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ahb_slave_mux_if.sv
// AHB-Lite bus bundle between the system master and the slave mux.
// "slave" is the mux's view of the bus; "master" is the driving side (master plus slaves).
interface ahb_slave_mux_if #(
  parameter int HADDR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int HSLV_NUM    = 8
);
  logic [HADDR_WIDTH-1:0]         haddr;
  logic [1:0]                     htrans;
  logic [HSLV_NUM-1:0]            hsel_o;
  logic                           hready_o;
  logic                           hresp_o;
  logic [DATA_WIDTH-1:0]          hrdata_o;
  logic [HSLV_NUM-1:0]            hreadyout_i;
  logic [HSLV_NUM-1:0]            hresp_i;
  logic [HSLV_NUM*DATA_WIDTH-1:0] hrdata_i;

  modport slave (
    input  haddr, htrans, hreadyout_i, hresp_i, hrdata_i,
    output hsel_o, hready_o, hresp_o, hrdata_o
  );

  modport master (
    output haddr, htrans, hreadyout_i, hresp_i, hrdata_i,
    input  hsel_o, hready_o, hresp_o, hrdata_o
  );
endinterface

// File: rtl/ahb_slave_mux.sv
// AHB-Lite address decoder / response mux with an internal ERROR-returning default slave.
// Optional decode-error log enabled by defining AHB_MUX_ERR_LOG_EN.
module ahb_slave_mux #(
  parameter int HADDR_WIDTH = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int HSLV_NUM    = 8
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  ahb_slave_mux_if.slave         bus
`ifdef AHB_MUX_ERR_LOG_EN
  ,
  output logic                   err_valid_o,
  output logic [HADDR_WIDTH-1:0] err_addr_o,
  input  logic                   err_clr_i
`endif
);

  // Index 15 can never be a slave (HSLV_NUM <= 15), so it encodes the default slave.
  localparam logic [3:0] DSEL_DEF = 4'hF;
  localparam logic [3:0] SLV_NUM  = 4'(HSLV_NUM);

  typedef enum logic [1:0] {S_OKAY, S_ERR1, S_ERR2} def_state_t;

  def_state_t            r_state;
  def_state_t            w_state_nxt;
  logic [3:0]            r_dsel;
  logic [3:0]            w_idx;
  logic                  w_mapped;
  logic                  w_xfer_err;
  logic                  w_def_ready;
  logic                  w_def_resp;
  logic                  w_hready;
  logic                  w_hresp;
  logic [DATA_WIDTH-1:0] w_hrdata;
  logic                  w_unused_bits;

  assign w_idx         = bus.haddr[31:28];
  assign w_mapped      = (w_idx < SLV_NUM);
  assign w_xfer_err    = w_hready & bus.htrans[1] & ~w_mapped;
  assign w_unused_bits = &{1'b0, bus.haddr, bus.htrans[0]};

  always_comb begin
    bus.hsel_o = '0;
    for (int i = 0; i < HSLV_NUM; i++) begin
      if (w_idx == 4'(i)) bus.hsel_o[i] = 1'b1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_dsel <= DSEL_DEF;
    end else if (w_hready) begin
      r_dsel <= w_mapped ? w_idx : DSEL_DEF;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) r_state <= S_OKAY;
    else          r_state <= w_state_nxt;
  end

  // ERR states are only reachable with r_dsel = DEF, so a real owner keeps the FSM in OKAY.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_OKAY:  if (w_xfer_err) w_state_nxt = S_ERR1;
      S_ERR1:  w_state_nxt = S_ERR2;
      S_ERR2:  w_state_nxt = w_xfer_err ? S_ERR1 : S_OKAY;
      default: w_state_nxt = S_OKAY;
    endcase
  end

  always_comb begin
    w_def_ready = 1'b1;
    w_def_resp  = 1'b0;
    case (r_state)
      S_ERR1: begin
        w_def_ready = 1'b0;
        w_def_resp  = 1'b1;
      end
      S_ERR2: begin
        w_def_ready = 1'b1;
        w_def_resp  = 1'b1;
      end
      default: begin
        w_def_ready = 1'b1;
        w_def_resp  = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_hready = w_def_ready;
    w_hresp  = w_def_resp;
    w_hrdata = '0;
    for (int i = 0; i < HSLV_NUM; i++) begin
      if (r_dsel == 4'(i)) begin
        w_hready = bus.hreadyout_i[i];
        w_hresp  = bus.hresp_i[i];
        w_hrdata = bus.hrdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign bus.hready_o = w_hready;
  assign bus.hresp_o  = w_hresp;
  assign bus.hrdata_o = w_hrdata;

`ifdef AHB_MUX_ERR_LOG_EN
  logic                   r_err_valid;
  logic [HADDR_WIDTH-1:0] r_err_addr;

  // A new capture takes priority over a simultaneous clear.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
    end else if (w_xfer_err) begin
      r_err_valid <= 1'b1;
      r_err_addr  <= bus.haddr;
    end else if (err_clr_i) begin
      r_err_valid <= 1'b0;
    end
  end

  assign err_valid_o = r_err_valid;
  assign err_addr_o  = r_err_addr;
`endif

endmodule

// File: tb/tb_ahb_slave_mux.sv
// Bench for ahb_slave_mux: directed protocol scenarios plus randomized traffic
// checked every cycle against a data-phase-level behavioural model.
module tb_ahb_slave_mux;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 8;

  logic hclk;
  logic hresetn;
  int   checks   = 0;
  int   failures = 0;

  ahb_slave_mux_if #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW), .HSLV_NUM(N)) bus ();

`ifdef AHB_MUX_ERR_LOG_EN
  logic          err_valid;
  logic [AW-1:0] err_addr;
  logic          err_clr;
`endif

  ahb_slave_mux #(.HADDR_WIDTH(AW), .DATA_WIDTH(DW), .HSLV_NUM(N)) dut (
    .hclk    (hclk),
    .hresetn (hresetn),
    .bus     (bus.slave)
`ifdef AHB_MUX_ERR_LOG_EN
    ,
    .err_valid_o (err_valid),
    .err_addr_o  (err_addr),
    .err_clr_i   (err_clr)
`endif
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  // Model: who owns the current data phase (-1 = default slave) and which
  // cycle of a two-cycle ERROR response we are in (0 = none).
  int          m_owner   = -1;
  int          m_err_cyc = 0;
  logic        m_log_v   = 1'b0;
  logic [31:0] m_log_a   = '0;

  function automatic logic model_ready();
    if (m_owner >= 0) return bus.hreadyout_i[m_owner];
    return (m_err_cyc != 1);
  endfunction

  function automatic logic model_resp();
    if (m_owner >= 0) return bus.hresp_i[m_owner];
    return (m_err_cyc != 0);
  endfunction

  function automatic logic [DW-1:0] model_rdata();
    if (m_owner >= 0) return bus.hrdata_i[m_owner*DW +: DW];
    return '0;
  endfunction

  function automatic logic [N-1:0] model_hsel();
    int idx;
    idx = int'(bus.haddr[31:28]);
    if (idx < N) return N'(1) << idx;
    return '0;
  endfunction

  function automatic logic model_new_err();
    return model_ready() && bus.htrans[1] && (int'(bus.haddr[31:28]) >= N);
  endfunction

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      m_owner   <= -1;
      m_err_cyc <= 0;
      m_log_v   <= 1'b0;
      m_log_a   <= '0;
    end else begin
`ifdef AHB_MUX_ERR_LOG_EN
      if (model_new_err()) begin
        m_log_v <= 1'b1;
        m_log_a <= bus.haddr;
      end else if (err_clr) begin
        m_log_v <= 1'b0;
      end
`endif
      if (model_ready()) begin
        m_owner   <= (int'(bus.haddr[31:28]) < N) ? int'(bus.haddr[31:28]) : -1;
        m_err_cyc <= model_new_err() ? 1 : 0;
      end else if (m_owner < 0) begin
        m_err_cyc <= 2;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge hclk) begin
    check("cmp_hsel",   64'(bus.hsel_o),   64'(model_hsel()));
    check("cmp_hready", 64'(bus.hready_o), 64'(model_ready()));
    check("cmp_hresp",  64'(bus.hresp_o),  64'(model_resp()));
    check("cmp_hrdata", 64'(bus.hrdata_o), 64'(model_rdata()));
`ifdef AHB_MUX_ERR_LOG_EN
    check("cmp_err_valid", 64'(err_valid), 64'(m_log_v));
    check("cmp_err_addr",  64'(err_addr),  64'(m_log_a));
`endif
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  task automatic set_xfer(input logic [31:0] a, input logic [1:0] t);
    bus.haddr  = a;
    bus.htrans = t;
  endtask

  function automatic logic [DW-1:0] slot_val(input int i);
    return 32'hD000_0000 | 32'(i);
  endfunction

  task automatic default_slaves();
    bus.hreadyout_i = '1;
    bus.hresp_i     = '0;
    for (int i = 0; i < N; i++) bus.hrdata_i[i*DW +: DW] = slot_val(i);
  endtask

  initial begin
    hresetn = 1'b0;
    set_xfer(32'h3000_0000, 2'd0);
    default_slaves();
`ifdef AHB_MUX_ERR_LOG_EN
    err_clr = 1'b0;
`endif
    @(negedge hclk);
    check("rst_hsel",   64'(bus.hsel_o),   64'h08);
    check("rst_hready", 64'(bus.hready_o), 64'h1);
    check("rst_hresp",  64'(bus.hresp_o),  64'h0);
    check("rst_hrdata", 64'(bus.hrdata_o), 64'h0);
    @(negedge hclk);
    hresetn = 1'b1;

    // APB region read with three wait states
    step(); set_xfer(32'h4000_0010, 2'd2);
    @(negedge hclk);
    check("apb_hsel", 64'(bus.hsel_o), 64'h10);
    step(); set_xfer(32'h0, 2'd0); bus.hreadyout_i[4] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      check("apb_wait", 64'(bus.hready_o), 64'h0);
      if (k < 2) step();
    end
    step(); bus.hreadyout_i[4] = 1'b1; bus.hrdata_i[4*DW +: DW] = 32'hA5A5_1234;
    @(negedge hclk);
    check("apb_done_ready", 64'(bus.hready_o), 64'h1);
    check("apb_rdata",      64'(bus.hrdata_o), 64'hA5A5_1234);
    step(); bus.hrdata_i[4*DW +: DW] = slot_val(4);

    // Back-to-back to slaves 1 and 2
    set_xfer(32'h1000_0000, 2'd2);
    step(); set_xfer(32'h2000_0004, 2'd2);
    @(negedge hclk);
    check("b2b_rdata1", 64'(bus.hrdata_o), 64'hD000_0001);
    step(); set_xfer(32'h0, 2'd0);
    @(negedge hclk);
    check("b2b_rdata2", 64'(bus.hrdata_o), 64'hD000_0002);
    check("b2b_ready2", 64'(bus.hready_o), 64'h1);

    // Unmapped NONSEQ then unmapped IDLE
    step(); set_xfer(32'hF000_0000, 2'd2);
    @(negedge hclk);
    check("unm_hsel", 64'(bus.hsel_o), 64'h0);
    step(); set_xfer(32'h0, 2'd0);
    @(negedge hclk);
    check("unm_err1", 64'({bus.hready_o, bus.hresp_o}), 64'b01);
    check("unm_rdata", 64'(bus.hrdata_o), 64'h0);
    step();
    @(negedge hclk);
    check("unm_err2", 64'({bus.hready_o, bus.hresp_o}), 64'b11);
    step();
    @(negedge hclk);
    check("unm_okay", 64'({bus.hready_o, bus.hresp_o}), 64'b10);
    step(); set_xfer(32'hF000_0000, 2'd0);
    step(); set_xfer(32'h0, 2'd0);
    @(negedge hclk);
    check("unm_idle", 64'({bus.hready_o, bus.hresp_o}), 64'b10);

    // Slave 3 two-cycle ERROR pass-through; dsel must hold
    step(); set_xfer(32'h3000_0000, 2'd2);
    step(); set_xfer(32'h5000_0000, 2'd2); bus.hreadyout_i[3] = 1'b0; bus.hresp_i[3] = 1'b1;
    @(negedge hclk);
    check("serr_1", 64'({bus.hready_o, bus.hresp_o}), 64'b01);
    step(); bus.hreadyout_i[3] = 1'b1;
    @(negedge hclk);
    check("serr_2", 64'({bus.hready_o, bus.hresp_o}), 64'b11);
    check("serr_hold", 64'(bus.hrdata_o), 64'hD000_0003);
    step(); bus.hresp_i[3] = 1'b0; set_xfer(32'h0, 2'd0);
    @(negedge hclk);
    check("serr_next", 64'(bus.hrdata_o), 64'hD000_0005);

    // Reset in the middle of a stalled data phase
    step(); set_xfer(32'h6000_0000, 2'd2);
    step(); set_xfer(32'h0, 2'd0); bus.hreadyout_i[6] = 1'b0;
    @(negedge hclk);
    check("mid_stall", 64'(bus.hready_o), 64'h0);
    #1 hresetn = 1'b0;
    #1;
    check("mid_rst", 64'({bus.hready_o, bus.hresp_o}), 64'b10);
    check("mid_rst_rdata", 64'(bus.hrdata_o), 64'h0);
    @(negedge hclk);
    hresetn = 1'b1;
    bus.hreadyout_i[6] = 1'b1;
    step(); set_xfer(32'h2000_0000, 2'd2);
    step(); set_xfer(32'h0, 2'd0);
    @(negedge hclk);
    check("post_rst_rdata", 64'(bus.hrdata_o), 64'hD000_0002);

`ifdef AHB_MUX_ERR_LOG_EN
    step(); set_xfer(32'h9000_0040, 2'd2);
    step(); set_xfer(32'hA000_0000, 2'd2);
    @(negedge hclk);
    check("log_valid1", 64'(err_valid), 64'h1);
    check("log_addr1",  64'(err_addr),  64'h9000_0040);
    step(); err_clr = 1'b1;
    step(); err_clr = 1'b0; set_xfer(32'h0, 2'd0);
    @(negedge hclk);
    check("log_valid2", 64'(err_valid), 64'h1);
    check("log_addr2",  64'(err_addr),  64'hA000_0000);
    step(); err_clr = 1'b1;
    step(); err_clr = 1'b0;
    @(negedge hclk);
    check("log_cleared", 64'(err_valid), 64'h0);
    check("log_addr_kept", 64'(err_addr), 64'hA000_0000);
`endif

    // Randomized traffic; the per-cycle compare process does the checking
    for (int n = 0; n < 2000; n++) begin
      step();
      set_xfer({4'($urandom_range(0, 15)), 28'($urandom)}, 2'($urandom_range(0, 3)));
      for (int i = 0; i < N; i++) begin
        bus.hreadyout_i[i]        = ($urandom_range(0, 3) != 0);
        bus.hresp_i[i]            = ($urandom_range(0, 5) == 0);
        bus.hrdata_i[i*DW +: DW]  = $urandom;
      end
`ifdef AHB_MUX_ERR_LOG_EN
      err_clr = ($urandom_range(0, 7) == 0);
`endif
      if (n == 1000) begin
        hresetn = 1'b0;
        @(negedge hclk);
        hresetn = 1'b1;
      end
    end

    step();
    default_slaves();
    set_xfer(32'h0, 2'd0);
    @(negedge hclk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
